// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the fetch/PC sequencer.
//   - state_e   : fetch sequencer state encoding
//   - PCSEL_*   : PC-select codes driven by the main control unit
//   - PC_RESET_VECTOR : default PC after reset
//   - pc_misaligned() : true when an address is not word aligned
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_e;

  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_JUMP   = 2'b10;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

  function automatic logic pc_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// next_pc_select: combinational next-PC choice at instruction retire.
// Ports:
//   i_pc            current PC
//   i_pc_sel        2-bit PC-select code (11 behaves as pc+4)
//   i_zero_flag     ALU zero flag (qualifies the branch)
//   i_branch_target branch destination
//   i_jump_target   jump destination
//   o_next_pc       selected next PC
//   o_misaligned    selected next PC is not word aligned
module next_pc_select
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pc_sel,
  input  logic        i_zero_flag,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  always_comb begin
    // Sequential address wraps modulo 2^32 by plain 32-bit addition.
    o_next_pc = i_pc + 32'd4;
    case (i_pc_sel)
      PCSEL_BRANCH: if (i_zero_flag) o_next_pc = i_branch_target;
      PCSEL_JUMP:   o_next_pc = i_jump_target;
      default:      o_next_pc = i_pc + 32'd4;
    endcase
    o_misaligned = pc_misaligned(o_next_pc);
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: multi-cycle fetch / PC sequencer for the rv32i core.
// Owns the PC, runs the imem request/response handshake, holds one fetched
// instruction for execute, and selects the next PC when execute retires.
//
// Optional build macro: PC_FETCH_TIMEOUT_EN enables a WAIT-state watchdog
// that re-requests the same PC after TIMEOUT_CYCLES cycles without a response.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req/addr     fetch request and address (addr driven from pc)
//   imem_ready        request accepted when imem_req & imem_ready
//   imem_valid/rdata  response strobe and instruction word
//   instr_out/valid   latched instruction, valid throughout EXEC
//   core_done         retire pulse from execute
//   pc_mux_control    next-PC select code; zero_flag, branch_target,
//                     jump_target sampled with core_done
//   halt_req          stop at the next instruction boundary
//   pc                current PC
//   misaligned_fault  sticky misaligned next-PC fault
//   fetch_timeout     watchdog pulse (0 when the watchdog is not built)
//   busy              low only in HALTED
module pc_fetch_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = PC_RESET_VECTOR,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        core_done,
  input  logic [1:0]  pc_mux_control,
  input  logic        zero_flag,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        misaligned_fault,
  output logic        fetch_timeout,
  output logic        busy
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic        r_fault;
  logic        r_busy;
  logic [31:0] w_next_pc;
  logic        w_misaligned;

  // Legal watchdog range is 2..255; an out-of-range value shows up as this
  // named block in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

`ifdef PC_FETCH_TIMEOUT_EN
  logic [7:0]  r_wait_cnt;
  logic        r_fetch_timeout;
  // The counter holds completed WAIT cycles, so expiry is detected on the
  // edge that ends the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

  next_pc_select u_next_pc_select (
    .i_pc            (r_pc),
    .i_pc_sel        (pc_mux_control),
    .i_zero_flag     (zero_flag),
    .i_branch_target (branch_target),
    .i_jump_target   (jump_target),
    .o_next_pc       (w_next_pc),
    .o_misaligned    (w_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_busy        <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
      r_wait_cnt      <= '0;
      r_fetch_timeout <= 1'b0;
`endif
    end else begin
`ifdef PC_FETCH_TIMEOUT_EN
      r_fetch_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (halt_req) begin
            r_state <= HALTED;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= REQ;
            r_imem_req <= 1'b1;
          end
        end
        REQ: begin
          // Responses seen here are stray and ignored.
          if (imem_ready) begin
            r_state    <= WAIT;
            r_imem_req <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (imem_valid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= EXEC;
          end
`ifdef PC_FETCH_TIMEOUT_EN
          else if (r_wait_cnt == TO_LAST) begin
            r_fetch_timeout <= 1'b1;
            r_state         <= REQ;
            r_imem_req      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        EXEC: begin
          if (core_done) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              // PC is left on the faulting instruction for debug.
              r_fault <= 1'b1;
              r_state <= HALTED;
              r_busy  <= 1'b0;
            end else begin
              r_pc <= w_next_pc;
              if (halt_req) begin
                r_state <= HALTED;
                r_busy  <= 1'b0;
              end else begin
                r_state    <= REQ;
                r_imem_req <= 1'b1;
              end
            end
          end
        end
        HALTED: begin
          // A misaligned fault parks the sequencer here until reset.
          if (!r_fault && !halt_req) begin
            r_state    <= REQ;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_busy        <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req         = r_imem_req;
  assign imem_addr        = r_pc;
  assign instr_out        = r_instr;
  assign instr_valid      = r_instr_valid;
  assign pc               = r_pc;
  assign misaligned_fault = r_fault;
  assign busy             = r_busy;
`ifdef PC_FETCH_TIMEOUT_EN
  assign fetch_timeout    = r_fetch_timeout;
`else
  assign fetch_timeout    = 1'b0;
`endif

endmodule
